// File: rtl/ring_host_injector.sv
// Ring station in front of a gpc_4t_tile ring input: re-registers ring traffic,
// injects queued host RD/WR requests into empty slots and strips local responses.
module ring_host_injector #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        QClk,
  input  logic        RstQnnnL,
  input  logic [7:0]  StationId,

  input  logic        RingInputValidQ500H,
  input  logic [1:0]  RingInputOpcodeQ500H,
  input  logic [31:0] RingInputAddressQ500H,
  input  logic [31:0] RingInputDataQ500H,

  output logic        RingOutputValidQ501H,
  output logic [1:0]  RingOutputOpcodeQ501H,
  output logic [31:0] RingOutputAddressQ501H,
  output logic [31:0] RingOutputDataQ501H,

  input  logic        HostReqValid,
  output logic        HostReqReady,
  input  logic [1:0]  HostReqOpcode,
  input  logic [31:0] HostReqAddress,
  input  logic [31:0] HostReqData,

  output logic        HostRspValid,
  output logic [1:0]  HostRspOpcode,
  output logic [31:0] HostRspData,

  output logic [2:0]  OutstandingCnt,
  output logic        OrphanRspErr
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] OP_RD     = 2'b00;
  localparam logic [1:0] OP_WR     = 2'b01;
  localparam logic [1:0] OP_RD_RSP = 2'b10;
  localparam logic [1:0] OP_WR_RSP = 2'b11;

  typedef struct packed {
    logic [1:0]  opcode;
    logic [31:0] address;
    logic [31:0] data;
  } t_req;

  t_req            r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_count;
  logic [2:0]      r_outstanding;
  logic            r_orphan;

  logic            w_full;
  logic            w_push;
  logic            w_consume;
  logic            w_slot_empty;
  logic            w_can_issue;
  logic            w_inject;
  t_req            w_head;

  // Ready depends only on registered occupancy, never on HostReqValid.
  assign w_full       = (r_count == (PW+1)'(FIFO_DEPTH));
  assign HostReqReady = !w_full;

  // Illegal opcodes complete the handshake but are silently discarded.
  assign w_push = HostReqValid && HostReqReady &&
                  ((HostReqOpcode == OP_RD) || (HostReqOpcode == OP_WR));

  assign w_consume = RingInputValidQ500H &&
                     ((RingInputOpcodeQ500H == OP_RD_RSP) ||
                      (RingInputOpcodeQ500H == OP_WR_RSP)) &&
                     (RingInputAddressQ500H[31:24] == StationId);

  assign w_slot_empty = !RingInputValidQ500H || w_consume;
  assign w_can_issue  = (r_outstanding < 3'(MAX_OUTSTANDING));
  assign w_inject     = w_slot_empty && (r_count != '0) && w_can_issue;
  assign w_head       = r_mem[r_rd_ptr];

  // NOTE: the storage array carries no reset; pointers and count define which entries are live.
  always_ff @(posedge QClk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{opcode: HostReqOpcode, address: HostReqAddress, data: HostReqData};
    end
  end

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_inject) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_inject})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Pass-through has priority; an empty slot carries the FIFO head or an idle RD/0/0.
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      RingOutputValidQ501H   <= 1'b0;
      RingOutputOpcodeQ501H  <= OP_RD;
      RingOutputAddressQ501H <= '0;
      RingOutputDataQ501H    <= '0;
    end else if (RingInputValidQ500H && !w_consume) begin
      RingOutputValidQ501H   <= 1'b1;
      RingOutputOpcodeQ501H  <= RingInputOpcodeQ500H;
      RingOutputAddressQ501H <= RingInputAddressQ500H;
      RingOutputDataQ501H    <= RingInputDataQ500H;
    end else if (w_inject) begin
      RingOutputValidQ501H   <= 1'b1;
      RingOutputOpcodeQ501H  <= w_head.opcode;
      RingOutputAddressQ501H <= w_head.address;
      RingOutputDataQ501H    <= w_head.data;
    end else begin
      RingOutputValidQ501H   <= 1'b0;
      RingOutputOpcodeQ501H  <= OP_RD;
      RingOutputAddressQ501H <= '0;
      RingOutputDataQ501H    <= '0;
    end
  end

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      HostRspValid  <= 1'b0;
      HostRspOpcode <= OP_RD;
      HostRspData   <= '0;
    end else begin
      HostRspValid <= w_consume;
      if (w_consume) begin
        HostRspOpcode <= RingInputOpcodeQ500H;
        HostRspData   <= RingInputDataQ500H;
      end
    end
  end

  // A response arriving with nothing outstanding is flagged and does not underflow.
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      r_outstanding <= '0;
      r_orphan      <= 1'b0;
    end else begin
      case ({w_inject, w_consume})
        2'b10: r_outstanding <= r_outstanding + 1'b1;
        2'b01: begin
          if (r_outstanding == '0) r_orphan <= 1'b1;
          else                     r_outstanding <= r_outstanding - 1'b1;
        end
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign OutstandingCnt = r_outstanding;
  assign OrphanRspErr   = r_orphan;

endmodule

// File: tb/tb_ring_host_injector.sv
// Scoreboard bench for ring_host_injector: expected slot/response contents are
// queued with each stimulus cycle and compared one cycle later.
module tb_ring_host_injector;

  typedef struct packed {
    logic        v;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] d;
  } pkt_t;

  typedef struct packed {
    pkt_t ring;
    pkt_t rsp;
  } exp_t;

  localparam logic [1:0] RD = 2'b00, WR = 2'b01, RD_RSP = 2'b10, WR_RSP = 2'b11;
  localparam pkt_t IDLE = '0;

  logic        QClk = 1'b0;
  logic        RstQnnnL;
  logic [7:0]  StationId;
  logic        RingInputValidQ500H;
  logic [1:0]  RingInputOpcodeQ500H;
  logic [31:0] RingInputAddressQ500H;
  logic [31:0] RingInputDataQ500H;
  logic        RingOutputValidQ501H;
  logic [1:0]  RingOutputOpcodeQ501H;
  logic [31:0] RingOutputAddressQ501H;
  logic [31:0] RingOutputDataQ501H;
  logic        HostReqValid;
  logic        HostReqReady;
  logic [1:0]  HostReqOpcode;
  logic [31:0] HostReqAddress;
  logic [31:0] HostReqData;
  logic        HostRspValid;
  logic [1:0]  HostRspOpcode;
  logic [31:0] HostRspData;
  logic [2:0]  OutstandingCnt;
  logic        OrphanRspErr;

  exp_t exp_q[$];
  pkt_t req_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 QClk = ~QClk;

  ring_host_injector #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(4)) dut (
    .QClk                   (QClk),
    .RstQnnnL               (RstQnnnL),
    .StationId              (StationId),
    .RingInputValidQ500H    (RingInputValidQ500H),
    .RingInputOpcodeQ500H   (RingInputOpcodeQ500H),
    .RingInputAddressQ500H  (RingInputAddressQ500H),
    .RingInputDataQ500H     (RingInputDataQ500H),
    .RingOutputValidQ501H   (RingOutputValidQ501H),
    .RingOutputOpcodeQ501H  (RingOutputOpcodeQ501H),
    .RingOutputAddressQ501H (RingOutputAddressQ501H),
    .RingOutputDataQ501H    (RingOutputDataQ501H),
    .HostReqValid           (HostReqValid),
    .HostReqReady           (HostReqReady),
    .HostReqOpcode          (HostReqOpcode),
    .HostReqAddress         (HostReqAddress),
    .HostReqData            (HostReqData),
    .HostRspValid           (HostRspValid),
    .HostRspOpcode          (HostRspOpcode),
    .HostRspData            (HostRspData),
    .OutstandingCnt         (OutstandingCnt),
    .OrphanRspErr           (OrphanRspErr)
  );

  function automatic pkt_t pk(logic v, logic [1:0] op, logic [31:0] a, logic [31:0] d);
    return {v, op, a, d};
  endfunction

  task automatic check(input string tag, input logic [66:0] got, input logic [66:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic pkt_t ring_out();
    return {RingOutputValidQ501H, RingOutputOpcodeQ501H, RingOutputAddressQ501H, RingOutputDataQ501H};
  endfunction

  task automatic chk_cnt(input int exp);
    check("outstanding", 67'(OutstandingCnt), 67'(exp));
  endtask

  // Drive one cycle of ring/host stimulus, queue its expectation, compare after the edge.
  task automatic step(input pkt_t rin, input pkt_t hin, input pkt_t exp_ring, input pkt_t exp_rsp);
    exp_t e;
    RingInputValidQ500H   = rin.v;
    RingInputOpcodeQ500H  = rin.op;
    RingInputAddressQ500H = rin.a;
    RingInputDataQ500H    = rin.d;
    HostReqValid          = hin.v;
    HostReqOpcode         = hin.op;
    HostReqAddress        = hin.a;
    HostReqData           = hin.d;
    exp_q.push_back({exp_ring, exp_rsp});
    @(posedge QClk);
    #1;
    e = exp_q.pop_front();
    check("ring", ring_out(), e.ring);
    check("rsp_valid", 67'(HostRspValid), 67'(e.rsp.v));
    if (e.rsp.v) check("rsp", 67'({HostRspOpcode, HostRspData}), 67'({e.rsp.op, e.rsp.d}));
  endtask

  initial begin
    int   accepted;
    logic exp_ready;
    pkt_t r;

    RstQnnnL = 1'b0;
    StationId = 8'h01;
    RingInputValidQ500H = 1'b0; RingInputOpcodeQ500H = RD;
    RingInputAddressQ500H = '0; RingInputDataQ500H = '0;
    HostReqValid = 1'b0; HostReqOpcode = RD; HostReqAddress = '0; HostReqData = '0;

    #12;
    check("rst_ring", ring_out(), IDLE);
    check("rst_rsp_valid", 67'(HostRspValid), 67'(0));
    check("rst_ready", 67'(HostReqReady), 67'(1));
    chk_cnt(0);
    check("rst_orphan", 67'(OrphanRspErr), 67'(0));
    @(negedge QClk);
    RstQnnnL = 1'b1;

    // Pass-through wins over a non-empty FIFO.
    step(pk(1, WR, 32'h0200_0001, 32'h0200_0001), pk(1, RD, 32'h0200_0010, 0),
         pk(1, WR, 32'h0200_0001, 32'h0200_0001), IDLE);
    chk_cnt(0);
    step(pk(1, WR, 32'h0200_0002, 32'h5), IDLE, pk(1, WR, 32'h0200_0002, 32'h5), IDLE);
    chk_cnt(0);
    step(IDLE, IDLE, pk(1, RD, 32'h0200_0010, 0), IDLE);
    chk_cnt(1);

    // No fall-through: a request pushed on an idle ring shows up one cycle later.
    step(IDLE, pk(1, WR, 32'h0200_0020, 32'h1234), IDLE, IDLE);
    step(IDLE, IDLE, pk(1, WR, 32'h0200_0020, 32'h1234), IDLE);
    chk_cnt(2);

    // Consume and inject in the same slot.
    step(IDLE, pk(1, RD, 32'h0200_0030, 0), IDLE, IDLE);
    step(pk(1, RD_RSP, 32'h0100_0010, 32'hDEAD_BEEF), IDLE,
         pk(1, RD, 32'h0200_0030, 0), pk(1, RD_RSP, 0, 32'hDEAD_BEEF));
    chk_cnt(2);
    step(pk(1, WR_RSP, 32'h0100_0000, 32'h77), IDLE, IDLE, pk(1, WR_RSP, 0, 32'h77));
    chk_cnt(1);
    step(pk(1, RD_RSP, 32'h0300_0000, 32'h99), IDLE, pk(1, RD_RSP, 32'h0300_0000, 32'h99), IDLE);
    chk_cnt(1);
    step(pk(1, RD_RSP, 32'h01FF_FFFF, 32'h1), IDLE, IDLE, pk(1, RD_RSP, 0, 32'h1));
    chk_cnt(0);
    check("orphan_clean", 67'(OrphanRspErr), 67'(0));

    // Illegal host opcode is dropped.
    step(IDLE, pk(1, WR_RSP, 32'h0200_0040, 0), IDLE, IDLE);
    step(IDLE, IDLE, IDLE, IDLE);
    chk_cnt(0);

    // Backpressure under continuous foreign traffic.
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      exp_ready = (accepted < 4);
      check("ready", 67'(HostReqReady), 67'(exp_ready));
      r = pk(1, (i % 2) ? WR : RD, 32'h0200_0100 + i, i);
      if (exp_ready) begin
        req_q.push_back(r);
        accepted++;
      end
      step(pk(1, WR, 32'h0200_1000 + i, 32'hA000 + i), r,
           pk(1, WR, 32'h0200_1000 + i, 32'hA000 + i), IDLE);
    end
    chk_cnt(0);

    // Idle ring drains exactly four injections.
    for (int i = 0; i < 4; i++) begin
      step(IDLE, IDLE, req_q.pop_front(), IDLE);
      chk_cnt(i + 1);
    end

    // Outstanding limit stalls injection until a response frees a credit.
    step(IDLE, pk(1, RD, 32'h0200_0200, 0), IDLE, IDLE);
    for (int i = 0; i < 3; i++) begin
      step(IDLE, IDLE, IDLE, IDLE);
      chk_cnt(4);
    end
    step(pk(1, RD_RSP, 32'h0100_0001, 32'h11), IDLE, IDLE, pk(1, RD_RSP, 0, 32'h11));
    chk_cnt(3);
    step(IDLE, IDLE, pk(1, RD, 32'h0200_0200, 0), IDLE);
    chk_cnt(4);
    for (int i = 0; i < 4; i++) begin
      step(pk(1, WR_RSP, 32'h0100_0000 + i, 32'h20 + i), IDLE, IDLE, pk(1, WR_RSP, 0, 32'h20 + i));
      chk_cnt(3 - i);
    end
    check("orphan_after_drain", 67'(OrphanRspErr), 67'(0));

    // Orphan response, sticky flag, then asynchronous reset mid-cycle.
    step(pk(1, RD_RSP, 32'h0100_0000, 32'hABCD), IDLE, IDLE, pk(1, RD_RSP, 0, 32'hABCD));
    chk_cnt(0);
    check("orphan_set", 67'(OrphanRspErr), 67'(1));
    step(pk(1, WR, 32'h0200_0300, 32'h3), pk(1, RD, 32'h0200_0300, 0),
         pk(1, WR, 32'h0200_0300, 32'h3), IDLE);
    check("orphan_sticky", 67'(OrphanRspErr), 67'(1));
    RingInputValidQ500H = 1'b0;
    HostReqValid = 1'b0;
    #2;
    RstQnnnL = 1'b0;
    #1;
    check("async_orphan", 67'(OrphanRspErr), 67'(0));
    check("async_ring", ring_out(), IDLE);
    check("async_ready", 67'(HostReqReady), 67'(1));
    @(negedge QClk);
    RstQnnnL = 1'b1;

    // The request queued before reset must be gone.
    step(IDLE, IDLE, IDLE, IDLE);
    step(IDLE, IDLE, IDLE, IDLE);
    chk_cnt(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
